// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
// Shared constants, types and helpers for the rate-1/3 turbo encoder slice.
//   K        number of info bits per frame
//   STEPS    trellis steps per frame (K info steps plus two termination steps)
//   SYM_W    width of one soft symbol (two's complement)
//   WORD_W   width of one output word
//   N_WORDS  output words per frame
//   FRAME_W  width of the complete soft frame
//   PI       interleaver: encoder 2 sees info[PI[k]] at step k
//   state_t  control FSM states
// -----------------------------------------------------------------------------
package turbo_pkg;

    localparam int K       = 5;
    localparam int STEPS   = 7;
    localparam int SYM_W   = 4;
    localparam int WORD_W  = 21;
    localparam int N_WORDS = 4;
    localparam int FRAME_W = 84;

    localparam logic [2:0] PI [0:K-1] = '{3'd3, 3'd0, 3'd4, 3'd1, 3'd2};

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        SEND
    } state_t;

    // Info bit for step idx; steps beyond the info block read as 0.
    function automatic logic info_bit(logic [K-1:0] info, logic [2:0] idx);
        return (idx < 3'(K)) ? info[idx] : 1'b0;
    endfunction

    // Interleaved info bit for step k (encoder 2 input).
    function automatic logic perm_bit(logic [K-1:0] info, logic [2:0] k);
        return (k < 3'(K)) ? info[PI[k]] : 1'b0;
    endfunction

    // BPSK map: bit 0 -> +amp, bit 1 -> -amp.
    function automatic logic [SYM_W-1:0] bpsk(logic b, int amp);
        logic [SYM_W-1:0] m;
        m = SYM_W'(amp);
        return b ? -m : m;
    endfunction

endpackage

// File: rtl/turbo_enc_if.sv
// -----------------------------------------------------------------------------
// turbo_enc_if
// Request/stream bundle of the turbo encoder.
//   start_i / data_i / ready_o        frame request, data_i sampled on start_i & ready_o
//   valid_o / out_ready_i / data_o    output word stream, transfer on valid_o & out_ready_i
//   last_o                            marks the final word of a frame
//   done_o                            one-cycle pulse after the final transfer
// Modports: slave = encoder side, master = requester/sink side.
// -----------------------------------------------------------------------------
interface turbo_enc_if;
    import turbo_pkg::*;

    logic              start_i;
    logic [K-1:0]      data_i;
    logic              ready_o;
    logic              valid_o;
    logic              out_ready_i;
    logic [WORD_W-1:0] data_o;
    logic              last_o;
    logic              done_o;

    modport slave (
        input  start_i, data_i, out_ready_i,
        output ready_o, valid_o, data_o, last_o, done_o
    );

    modport master (
        output start_i, data_i, out_ready_i,
        input  ready_o, valid_o, data_o, last_o, done_o
    );
endinterface

// File: rtl/turbo_rsc.sv
// -----------------------------------------------------------------------------
// turbo_rsc
// One recursive systematic convolutional (7,5) constituent encoder.
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   clr_i   synchronous clear of the trellis state
//   en_i    advance one trellis step
//   tail_i  termination step: input replaced by s1^s2 so the feedback is 0
//   u_i     info bit for this step
//   sys_o   systematic bit actually fed into the trellis
//   p_o     parity bit for this step
// -----------------------------------------------------------------------------
module turbo_rsc (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic tail_i,
    input  logic u_i,
    output logic sys_o,
    output logic p_o
);
    // state_q[1] = s1 (newest), state_q[0] = s2
    logic [1:0] state_q;
    logic       a;

    // Feedback a = u^s1^s2, parity p = a^s2; the tail input cancels the feedback.
    always_comb begin
        sys_o = tail_i ? (state_q[1] ^ state_q[0]) : u_i;
        a     = sys_o ^ state_q[1] ^ state_q[0];
        p_o   = a ^ state_q[0];
    end

    // Trellis state: cleared at frame start, shifted once per enabled step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else if (clr_i) begin
            state_q <= '0;
        end else if (en_i) begin
            state_q <= {a, state_q[1]};
        end
    end
endmodule

// File: rtl/turbo_enc.sv
// -----------------------------------------------------------------------------
// turbo_enc
// Rate-1/3 turbo encoder: 5 info bits through two RSC(7,5) encoders (the
// second via the interleaver PI), two termination steps, BPSK-mapped to 4-bit
// soft symbols and streamed as four 21-bit words, word 0 = frame[20:0] first.
//   clk_p_i    clock, rising edge
//   reset_p_i  asynchronous active-high reset (aborts any frame in progress)
//   bus        turbo_enc_if.slave request/stream bundle
// Parameters: AMP soft magnitude (1..7); LFSR_SEED noise LFSR reset value.
// Optional feature macro TURBO_ENC_NOISE_EN: adds LFSR-driven +/-1 noise to
// each symbol, saturated to [-AMP,+AMP]. Without it every symbol is +/-AMP.
// -----------------------------------------------------------------------------
module turbo_enc
    import turbo_pkg::*;
#(
    parameter int AMP = 7
`ifdef TURBO_ENC_NOISE_EN
    , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic        clk_p_i,
    input  logic        reset_p_i,
    turbo_enc_if.slave  bus
);
    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [1:0]           w_q, w_d;
    logic                 done_q, done_d;
    logic [K-1:0]         info_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 load, step, tail, valid;
    logic                 u1, u2, sys1, p1, p2;
    logic                 sys2_unused;
    logic [3*SYM_W-1:0]   triple;

    // Termination steps follow the info steps.
    always_comb begin
        tail = (k_q >= 3'(K));
        u1   = info_bit(info_q, k_q);
        u2   = perm_bit(info_q, k_q);
    end

    turbo_rsc u_enc1 (
        .clk_i  (clk_p_i),
        .rst_i  (reset_p_i),
        .clr_i  (load),
        .en_i   (step),
        .tail_i (tail),
        .u_i    (u1),
        .sys_o  (sys1),
        .p_o    (p1)
    );

    // Encoder 2 systematic bits duplicate (permuted) info and are not sent.
    turbo_rsc u_enc2 (
        .clk_i  (clk_p_i),
        .rst_i  (reset_p_i),
        .clr_i  (load),
        .en_i   (step),
        .tail_i (tail),
        .u_i    (u2),
        .sys_o  (sys2_unused),
        .p_o    (p2)
    );

`ifdef TURBO_ENC_NOISE_EN
    logic [15:0] lfsr_q;

    // Offset 01 -> +1, 10 -> -1, else 0; clipping keeps the sign intact.
    function automatic logic [SYM_W-1:0] add_noise(logic [SYM_W-1:0] sym, logic [1:0] n);
        logic signed [SYM_W:0] v;
        logic signed [SYM_W:0] lim;
        v   = signed'({sym[SYM_W-1], sym});
        lim = (SYM_W+1)'(AMP);
        case (n)
            2'b01:   v = v + (SYM_W+1)'(1);
            2'b10:   v = v - (SYM_W+1)'(1);
            default: v = v;
        endcase
        if (v > lim) begin
            v = lim;
        end else if (v < -lim) begin
            v = -lim;
        end
        return v[SYM_W-1:0];
    endfunction

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advancing every encode cycle.
    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Symbol j of the step takes its offset from lfsr bits [2j+1:2j].
    always_comb begin
        triple = {add_noise(bpsk(p2,   AMP), lfsr_q[5:4]),
                  add_noise(bpsk(p1,   AMP), lfsr_q[3:2]),
                  add_noise(bpsk(sys1, AMP), lfsr_q[1:0])};
    end
`else
    // Clean symbols: exactly +/-AMP.
    always_comb begin
        triple = {bpsk(p2, AMP), bpsk(p1, AMP), bpsk(sys1, AMP)};
    end
`endif

    // Next-state logic: latch request, run STEPS trellis steps, stream words.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    k_d     = '0;
                    state_d = ENC;
                end
            end
            ENC: begin
                step = 1'b1;
                if (k_q == 3'(STEPS - 1)) begin
                    w_d     = '0;
                    state_d = SEND;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            SEND: begin
                if (bus.out_ready_i) begin
                    if (w_q == 2'(N_WORDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, latched info bits, and the soft frame (step k fills
    // symbols 3k..3k+2, i.e. frame[12k+11:12k]).
    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
            info_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            done_q  <= done_d;
            if (load) begin
                info_q <= bus.data_i;
            end
            if (step) begin
                frame_q[3*SYM_W*k_q +: 3*SYM_W] <= triple;
            end
        end
    end

    // Stream outputs are decoded from the state and word index.
    always_comb begin
        valid       = (state_q == SEND);
        bus.ready_o = (state_q == IDLE);
        bus.valid_o = valid;
        bus.data_o  = valid ? frame_q[WORD_W*w_q +: WORD_W] : '0;
        bus.last_o  = valid && (w_q == 2'(N_WORDS - 1));
        bus.done_o  = done_q;
    end
endmodule

// File: tb/tb_turbo_enc.sv
// -----------------------------------------------------------------------------
// tb_turbo_enc
// Directed bench for turbo_enc (default build, AMP = 7). A table of info words
// with hand-derived systematic/parity sequences (MSB = step 0) is expanded to
// soft frames and compared word by word; extra sequences cover ignored start
// pulses, output backpressure and a reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_turbo_enc;
    import turbo_pkg::*;

    typedef struct {
        logic [K-1:0] data;
        logic [6:0]   sys;
        logic [6:0]   p1;
        logic [6:0]   p2;
    } vec_t;

    vec_t vec [0:4];
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    turbo_enc_if bus();

    turbo_enc dut (
        .clk_p_i   (clk),
        .reset_p_i (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Expand coded bits (bit 6 = step 0) into the soft frame: 0 -> 7, 1 -> -7.
    function automatic logic [FRAME_W-1:0] expFrame(vec_t v);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < STEPS; k++) begin
            f[12*k     +: 4] = v.sys[6-k] ? 4'h9 : 4'h7;
            f[12*k + 4 +: 4] = v.p1[6-k]  ? 4'h9 : 4'h7;
            f[12*k + 8 +: 4] = v.p2[6-k]  ? 4'h9 : 4'h7;
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [FRAME_W-1:0] act,
                               input logic [FRAME_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request for one cycle, then scramble data_i to prove it was latched.
    task automatic applyStimulus(input logic [K-1:0] d);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.data_i  = d;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.data_i  = ~d;
    endtask

    // Full frame: request, latency count, word stream with optional stall, done pulse.
    task automatic runFrame(input string tag, input vec_t v, input bit noisy,
                            input int stallWord, input int stallCycles);
        logic [FRAME_W-1:0] exp;
        int lat;
        int w;
        int stalled;
        int cycles;
        exp     = expFrame(v);
        lat     = 0;
        w       = 0;
        stalled = 0;
        cycles  = 0;
        applyStimulus(v.data);
        while (!bus.valid_o && lat < 20) begin
            checkOutput({tag, "/readyEnc"}, bus.ready_o, 0);
            if (noisy) begin
                bus.start_i = 1'b1;
                bus.data_i  = 5'b11111;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "/latency"}, lat, 7);
        while (w < N_WORDS && cycles < 64) begin
            cycles++;
            checkOutput({tag, "/word"}, bus.data_o, exp[WORD_W*w +: WORD_W]);
            checkOutput({tag, "/valid"}, bus.valid_o, 1);
            checkOutput({tag, "/last"}, bus.last_o, (w == N_WORDS - 1));
            checkOutput({tag, "/readySend"}, bus.ready_o, 0);
            checkOutput({tag, "/doneEarly"}, bus.done_o, 0);
            if (w == stallWord && stalled < stallCycles) begin
                bus.out_ready_i = 1'b0;
                stalled++;
            end else begin
                bus.out_ready_i = 1'b1;
                w++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.start_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        checkOutput({tag, "/sendCycles"}, cycles, N_WORDS + stallCycles);
        checkOutput({tag, "/done"}, bus.done_o, 1);
        checkOutput({tag, "/readyDone"}, bus.ready_o, 1);
        checkOutput({tag, "/validDone"}, bus.valid_o, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "/doneOnce"}, bus.done_o, 0);
        checkOutput({tag, "/validIdle"}, bus.valid_o, 0);
    endtask

    initial begin
        // data, sys, p1, p2 (leftmost bit = step 0)
        vec[0] = '{5'b00000, 7'b0000000, 7'b0000000, 7'b0000000};
        vec[1] = '{5'b00001, 7'b1000001, 7'b1110111, 7'b0111001};
        vec[2] = '{5'b11111, 7'b1111110, 7'b1011010, 7'b1011010};
        vec[3] = '{5'b10110, 7'b0110110, 7'b0100010, 7'b0010100};
        vec[4] = '{5'b01010, 7'b0101010, 7'b0110110, 7'b1111000};

        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.data_i      = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resetReady", bus.ready_o, 1);
        checkOutput("resetValid", bus.valid_o, 0);
        checkOutput("resetLast", bus.last_o, 0);
        checkOutput("resetDone", bus.done_o, 0);
        checkOutput("resetData", bus.data_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            runFrame($sformatf("vec%0d", i), vec[i], 1'b0, -1, 0);
        end

        $display("[TB] start pulses during ENC/SEND");
        runFrame("ignoreStart", vec[1], 1'b1, -1, 0);

        $display("[TB] backpressure on word 1");
        runFrame("stall", vec[2], 1'b0, 1, 5);

        $display("[TB] reset in the middle of SEND");
        applyStimulus(vec[4].data);
        repeat (7) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("preResetWord2", bus.data_o, expFrame(vec[4])[2*WORD_W +: WORD_W]);
        #1 rst = 1'b1;
        #1;
        checkOutput("abortValid", bus.valid_o, 0);
        checkOutput("abortReady", bus.ready_o, 1);
        checkOutput("abortData", bus.data_o, 0);
        checkOutput("abortLast", bus.last_o, 0);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("noReemit", bus.valid_o, 0);
            checkOutput("idleDone", bus.done_o, 0);
        end
        runFrame("afterReset", vec[3], 1'b0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
